pipeline_stall_controller: RTL and testbench

Central sequencer for the 5-stage pipeline. It merges the hazard-detection request, the branch mispredict from EX, the data-memory busy signal and the halt request into a single set of per-stage write-enable and flush controls. It owns the halt-drain sequence that retires in-flight instructions before asserting is_halted. It sits beside the hazard detection unit and drives the PC and all four pipeline registers.

---
 rtl/pipeline_stall_controller.sv | 149 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Pipeline sequencer: merges hazard/mispredict/mem_busy/halt into per-stage enables and flushes, and owns the halt drain.
// Optional performance counters are built when STALL_PERF_CNT_EN is defined; otherwise the counter outputs read 0.
module pipeline_stall_controller #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hazard,
  input  logic                 mispredict,
  input  logic                 mem_busy,
  input  logic                 halt_req,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_write,
  output logic                 ex_mem_write,
  output logic                 mem_wb_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 is_halted,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic [CNT_WIDTH-1:0] freeze_cnt
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           halted_q, halted_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    halted_d     = halted_q;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
          end else if (mispredict) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (halt_req) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            state_d     = DRAIN;
            drain_d     = DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (mem_busy) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
          end else begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            // Counter reaching zero still needs one more non-frozen cycle before halting.
            if (drain_q == '0) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end else begin
              drain_d = drain_q - 1'b1;
            end
          end
        end
        HALTED: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_write = 1'b0;
          mem_wb_write = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign is_halted = halted_q;
  assign state     = state_q;

`ifdef STALL_PERF_CNT_EN
  logic                 stall_ev, flush_ev, freeze_ev;
  logic [CNT_WIDTH-1:0] stall_q, flush_q, freeze_q;

  assign freeze_ev = mem_busy && (state_q == RUN || state_q == DRAIN);
  assign flush_ev  = (state_q == RUN) && !mem_busy && mispredict;
  assign stall_ev  = (state_q == RUN) && !mem_busy && !mispredict && hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if (stall_ev && stall_q != '1)   stall_q  <= stall_q + CNT_WIDTH'(1);
      if (flush_ev && flush_q != '1)   flush_q  <= flush_q + CNT_WIDTH'(1);
      if (freeze_ev && freeze_q != '1) freeze_q <= freeze_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
  assign freeze_cnt = freeze_q;
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_pipeline_stall_controller;

  localparam int unsigned DC = 3;
  localparam int unsigned CW = 32;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, hazard, mispredict, mem_busy, halt_req;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic          if_id_flush, id_ex_flush, is_halted;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  pipeline_stall_controller #(.DRAIN_CYCLES(DC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .hazard(hazard), .mispredict(mispredict),
    .mem_busy(mem_busy), .halt_req(halt_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .is_halted(is_halted), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0=running, 1=draining, 2=halted; left = non-frozen drain cycles still owed.
  int          m_mode = 0;
  int          m_left = 0;
  bit          m_halted = 1'b0;
  longint unsigned m_stall = 0, m_flush = 0, m_freeze = 0;
  localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;

  function automatic longint unsigned sat_inc(longint unsigned v);
    return (v == CMAX) ? v : v + 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_left = 0; m_halted = 1'b0;
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else if (m_mode == 0) begin
      if (mem_busy)        m_freeze = sat_inc(m_freeze);
      else if (mispredict) m_flush  = sat_inc(m_flush);
      else if (hazard)     m_stall  = sat_inc(m_stall);
      else if (halt_req) begin
        m_mode = 1; m_left = DC;
      end
    end else if (m_mode == 1) begin
      if (mem_busy) m_freeze = sat_inc(m_freeze);
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = 2; m_halted = 1'b1;
        end
      end
    end
  end

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  function automatic logic [6:0] exp_ctrl();
    if (reset)           return 7'b11111_00;
    if (m_mode == 2)     return 7'b00000_00;
    if (mem_busy)        return 7'b00000_00;
    if (m_mode == 1)     return 7'b01111_10;
    if (mispredict)      return 7'b11111_11;
    if (hazard)          return 7'b00111_01;
    if (halt_req)        return 7'b01111_10;
    return 7'b11111_00;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then compare every output to the model mid-cycle.
  task automatic drive(input bit r, input bit hz, input bit mp, input bit mb, input bit hq);
    logic [6:0] ctrl;
    @(negedge clk);
    reset = r; hazard = hz; mispredict = mp; mem_busy = mb; halt_req = hq;
    #1;
    ctrl = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write, if_id_flush, id_ex_flush};
    chk("ctrl", ctrl, exp_ctrl());
    chk("state", state, m_mode);
    chk("is_halted", is_halted, m_halted);
    chk("stall_cnt", stall_cnt, PERF ? m_stall : 0);
    chk("flush_cnt", flush_cnt, PERF ? m_flush : 0);
    chk("freeze_cnt", freeze_cnt, PERF ? m_freeze : 0);
  endtask

  initial begin
    reset = 1'b1; hazard = 1'b0; mispredict = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;

    drive(1, 0, 0, 0, 0);
    chk("lit_rst_pc", pc_write, 1);
    chk("lit_rst_flush", {if_id_flush, id_ex_flush}, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("lit_idle_state", state, 0);
    chk("lit_idle_halt", is_halted, 0);
    chk("lit_idle_writes", {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 5'b11111);
    chk("lit_idle_stall", stall_cnt, 0);

    drive(0, 1, 0, 0, 0);
    chk("lit_hz_pc", pc_write, 0);
    chk("lit_hz_ifid", if_id_write, 0);
    chk("lit_hz_idflush", id_ex_flush, 1);
    drive(0, 0, 0, 0, 0);
    chk("lit_hz_cnt", stall_cnt, PERF ? 1 : 0);

    drive(0, 1, 1, 0, 0);
    chk("lit_mp_flushes", {if_id_flush, id_ex_flush}, 2'b11);
    chk("lit_mp_pc", pc_write, 1);
    drive(0, 0, 0, 0, 0);
    chk("lit_mp_stall", stall_cnt, PERF ? 1 : 0);
    chk("lit_mp_flushcnt", flush_cnt, PERF ? 1 : 0);

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0);
      chk("lit_frz_writes", {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write}, 0);
    end
    drive(0, 0, 1, 0, 0);
    chk("lit_frz_release", {if_id_flush, id_ex_flush}, 2'b11);
    drive(0, 0, 0, 0, 0);
    chk("lit_frz_cnt", freeze_cnt, PERF ? 3 : 0);

    drive(0, 0, 0, 0, 1);
    chk("lit_halt_accept", {pc_write, if_id_flush}, 2'b01);
    drive(0, 0, 0, 0, 0); chk("lit_drain1", state, 1);
    drive(0, 0, 0, 1, 0); chk("lit_drain2", state, 1);
    drive(0, 0, 0, 1, 0); chk("lit_drain3", state, 1);
    drive(0, 0, 0, 0, 0); chk("lit_drain4", state, 1);
    drive(0, 0, 0, 0, 0); chk("lit_drain5", state, 1);
    drive(0, 0, 0, 0, 0);
    chk("lit_halted_state", state, 2);
    chk("lit_halted_flag", is_halted, 1);
    drive(0, 1, 0, 0, 0);
    chk("lit_halted_hz", {pc_write, if_id_write, id_ex_flush}, 0);
    drive(0, 0, 1, 0, 0);
    chk("lit_halted_mp", {if_id_flush, id_ex_flush, state}, 4'b0010);

    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("lit_rst_mid_pc", pc_write, 1);
    drive(0, 0, 0, 0, 0);
    chk("lit_rst_mid_state", state, 0);
    chk("lit_rst_mid_halt", is_halted, 0);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < int'(DC); i++) begin
      drive(0, 0, 0, 0, 0);
      chk("lit_redrain", state, 1);
    end
    drive(0, 0, 0, 0, 0);
    chk("lit_redrain_done", is_halted, 1);

    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
            $urandom_range(3) == 0, $urandom_range(15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
